// File: rtl/affine_addr_pkg.sv
// Shared types and default sizing for the affine address generator.
package affine_addr_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DIMS   = 3;
  localparam int DEF_CNT_W  = 16;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/affine_addr_gen_if.sv
// Control, configuration and address-stream signals of the affine address generator.
interface affine_addr_gen_if
  import affine_addr_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DIMS   = DEF_DIMS,
  parameter int CNT_W  = DEF_CNT_W
);
  logic                          start;
  logic                          abort;
  logic                          cfg_repeat;
  logic [ADDR_W-1:0]             cfg_base;
  logic [DIMS-1:0][CNT_W-1:0]    cfg_extent;
  logic [DIMS-1:0][ADDR_W-1:0]   cfg_stride;
  logic                          addr_valid;
  logic                          addr_ready;
  logic [ADDR_W-1:0]             addr;
  logic                          addr_last;
  logic                          busy;
  logic                          done;

  // The generator drives the address stream, so it is the master side.
  modport master (
    input  start, abort, cfg_repeat, cfg_base, cfg_extent, cfg_stride, addr_ready,
    output addr_valid, addr, addr_last, busy, done
  );

  modport slave (
    output start, abort, cfg_repeat, cfg_base, cfg_extent, cfg_stride, addr_ready,
    input  addr_valid, addr, addr_last, busy, done
  );
endinterface

// File: rtl/affine_dim_ctr.sv
// One loop dimension: latched extent/stride, iteration counter and origin register.
module affine_dim_ctr
  import affine_addr_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              reload_i,
  input  logic              advance_i,
  input  logic              sel_i,
  input  logic              clr_i,
  input  logic [CNT_W-1:0]  cfg_extent_i,
  input  logic [ADDR_W-1:0] cfg_stride_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic [ADDR_W-1:0] bcast_i,
  output logic              at_max_o,
  output logic              at_max_next_o,
  output logic [ADDR_W-1:0] sum_o
);

  logic [CNT_W-1:0]  ext_m1_q, ext_m1_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] stride_q, stride_d;
  logic [ADDR_W-1:0] origin_q, origin_d;
  logic [ADDR_W-1:0] origin_inc;

  assign origin_inc = origin_q + stride_q;

  always_comb begin
    ext_m1_d = ext_m1_q;
    stride_d = stride_q;
    cnt_d    = cnt_q;
    origin_d = origin_q;
    if (start_i) begin
      // An extent of zero runs the dimension once, like an extent of one.
      ext_m1_d = (cfg_extent_i == '0) ? '0 : cfg_extent_i - CNT_W'(1);
      stride_d = cfg_stride_i;
      cnt_d    = '0;
      origin_d = base_i;
    end else if (reload_i) begin
      cnt_d    = '0;
      origin_d = base_i;
    end else if (advance_i) begin
      if (sel_i) begin
        cnt_d    = cnt_q + CNT_W'(1);
        origin_d = origin_inc;
      end else if (clr_i) begin
        cnt_d    = '0;
        origin_d = bcast_i;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ext_m1_q <= '0;
      stride_q <= '0;
      cnt_q    <= '0;
      origin_q <= '0;
    end else begin
      ext_m1_q <= ext_m1_d;
      stride_q <= stride_d;
      cnt_q    <= cnt_d;
      origin_q <= origin_d;
    end
  end

  assign at_max_o      = (cnt_q == ext_m1_q);
  assign at_max_next_o = (cnt_d == ext_m1_d);
  // Only the stepping dimension contributes, so the top can OR all sums together.
  assign sum_o         = sel_i ? origin_inc : '0;

endmodule

// File: rtl/affine_addr_gen.sv
// Multi-dimensional affine address generator: FSM, carry selection and output registers.
module affine_addr_gen
  import affine_addr_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DIMS   = DEF_DIMS,
  parameter int CNT_W  = DEF_CNT_W
) (
  input logic               clk,
  input logic               rst,
  affine_addr_gen_if.master bus
);

  state_t                      state_q, state_d;
  logic                        valid_q, valid_d;
  logic                        last_q, last_d;
  logic                        done_q, done_d;
  logic                        repeat_q, repeat_d;
  logic [ADDR_W-1:0]           addr_q, addr_d;
  logic [ADDR_W-1:0]           base_q, base_d;

  logic                        xfer;
  logic                        dim_start, dim_reload, dim_advance;
  logic [DIMS-1:0]             at_max, at_max_next, sel, clr;
  logic [DIMS:0]               below_max;
  logic [DIMS-1:0][ADDR_W-1:0] sum;
  logic [ADDR_W-1:0]           bcast, base_load;

  assign xfer      = valid_q & bus.addr_ready;
  assign base_load = (state_q == IDLE) ? bus.cfg_base : base_q;

  // The stepping dimension is the lowest one not yet at its final count;
  // every dimension below it wraps and takes the stepping dimension's new origin.
  always_comb begin
    below_max    = '0;
    below_max[0] = 1'b1;
    for (int i = 0; i < DIMS; i++) begin
      below_max[i+1] = below_max[i] & at_max[i];
    end
    sel   = below_max[DIMS-1:0] & ~at_max;
    clr   = below_max[DIMS:1];
    bcast = '0;
    for (int i = 0; i < DIMS; i++) begin
      bcast = bcast | sum[i];
    end
  end

  for (genvar gi = 0; gi < DIMS; gi++) begin : g_dim
    affine_dim_ctr #(
      .ADDR_W (ADDR_W),
      .CNT_W  (CNT_W)
    ) u_dim (
      .clk           (clk),
      .rst           (rst),
      .start_i       (dim_start),
      .reload_i      (dim_reload),
      .advance_i     (dim_advance),
      .sel_i         (sel[gi]),
      .clr_i         (clr[gi]),
      .cfg_extent_i  (bus.cfg_extent[gi]),
      .cfg_stride_i  (bus.cfg_stride[gi]),
      .base_i        (base_load),
      .bcast_i       (bcast),
      .at_max_o      (at_max[gi]),
      .at_max_next_o (at_max_next[gi]),
      .sum_o         (sum[gi])
    );
  end

  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    last_d      = last_q;
    done_d      = 1'b0;
    repeat_d    = repeat_q;
    addr_d      = addr_q;
    base_d      = base_q;
    dim_start   = 1'b0;
    dim_reload  = 1'b0;
    dim_advance = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d   = RUN;
          dim_start = 1'b1;
          base_d    = bus.cfg_base;
          repeat_d  = bus.cfg_repeat;
          addr_d    = bus.cfg_base;
          valid_d   = 1'b1;
          last_d    = &at_max_next;
        end
      end
      RUN: begin
        if (bus.abort) begin
          state_d = IDLE;
          valid_d = 1'b0;
          last_d  = 1'b0;
          done_d  = 1'b1;
        end else if (xfer && last_q) begin
          if (repeat_q) begin
            dim_reload = 1'b1;
            addr_d     = base_q;
            last_d     = &at_max_next;
          end else begin
            state_d = IDLE;
            valid_d = 1'b0;
            last_d  = 1'b0;
            done_d  = 1'b1;
          end
        end else if (xfer) begin
          dim_advance = 1'b1;
          addr_d      = bcast;
          last_d      = &at_max_next;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      done_q   <= 1'b0;
      repeat_q <= 1'b0;
      addr_q   <= '0;
      base_q   <= '0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      done_q   <= done_d;
      repeat_q <= repeat_d;
      addr_q   <= addr_d;
      base_q   <= base_d;
    end
  end

  assign bus.addr_valid = valid_q;
  assign bus.addr       = addr_q;
  assign bus.addr_last  = last_q;
  assign bus.busy       = (state_q == RUN);
  assign bus.done       = done_q;

endmodule

// File: doc/affine_addr_gen.md
AFFINE_ADDR_GEN -- requirements
Module: affine_addr_gen

Interface
REQ-001 Parameter ADDR_W, default 32: address and stride width.
REQ-002 Parameter DIMS, default 3: number of loop dimensions; dimension 0 is innermost.
REQ-003 Parameter CNT_W, default 16: extent counter width.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 start  input  1  begin a scan; sampled only in IDLE.
REQ-007 abort  input  1  terminate the scan in progress.
REQ-008 cfg_repeat  input  1  when 1, restart from base after last address instead of stopping.
REQ-009 cfg_base  input  ADDR_W  first address of the scan.
REQ-010 cfg_extent  input  DIMS x CNT_W  iteration count per dimension; value 0 is treated as 1.
REQ-011 cfg_stride  input  DIMS x ADDR_W  per-dimension address increment, two's complement.
REQ-012 addr_valid  output  1  addr holds a valid address.
REQ-013 addr_ready  input  1  consumer accepts addr; a transfer occurs when addr_valid and addr_ready are both 1.
REQ-014 addr  output  ADDR_W  generated address.
REQ-015 addr_last  output  1  addr is the final address of the current pass.
REQ-016 busy  output  1  state is RUN.
REQ-017 done  output  1  one-cycle pulse when a scan ends, whether completed or aborted.

Function
REQ-018 The block SHALL implement two states, IDLE and RUN.
REQ-019 In IDLE, start=1 SHALL do all of the following on that edge:
- latch all cfg_* inputs;
- clear all counters;
- load every per-dimension origin register and addr with cfg_base;
- enter RUN with addr_valid=1 on the next cycle.
REQ-020 cfg_* changes while in RUN SHALL have no effect.
REQ-021 Each transfer SHALL advance the scan as follows:
- let k be the lowest dimension whose counter is below extent-1;
- increment counter k and clear counters 0..k-1;
- set origin[k] = origin[k] + stride[k];
- copy the new origin[k] into origin[0..k-1] and into addr.
REQ-022 Address arithmetic SHALL wrap modulo 2^ADDR_W; no multiplier is permitted.
REQ-023 When no transfer occurs, addr, addr_last and addr_valid SHALL hold their values.
REQ-024 addr_last SHALL equal 1 exactly when every counter equals its extent-1, registered together with addr.
REQ-025 On a transfer with addr_last=1 and cfg_repeat=0, the block SHALL return to IDLE, drop addr_valid and pulse done on the next cycle.
REQ-026 On a transfer with addr_last=1 and cfg_repeat=1, the block SHALL reload cfg_base, clear all counters and continue with no bubble cycle.
REQ-027 abort=1 in RUN SHALL force IDLE on the next edge, drop addr_valid and pulse done, even if a transfer occurs in the same cycle.
REQ-028 abort in IDLE SHALL be ignored; start and abort together in IDLE SHALL start a scan.
REQ-029 start in RUN SHALL be ignored.
REQ-030 With all extents equal to 1, the block SHALL emit exactly one address with addr_last=1.
REQ-031 The address sequence SHALL be independent of addr_ready timing; backpressure SHALL only stretch it.
REQ-032 A scan with no backpressure SHALL produce one address per cycle, with first addr_valid one cycle after start.

Reset
REQ-033 rst SHALL asynchronously force:
- IDLE state;
- addr_valid=0, addr_last=0, busy=0, done=0;
- addr=0, and all counters and origin registers cleared.
REQ-034 rst asserted mid-scan SHALL discard the scan without a done pulse.
REQ-035 After rst deasserts, the first start SHALL behave per REQ-019.

Structure
REQ-036 The package affine_addr_pkg SHALL hold:
- the state enumeration typedef;
- default values for ADDR_W, DIMS and CNT_W.
REQ-037 One sub-module, affine_dim_ctr, SHALL implement a single dimension's counter, carry and origin register, instantiated DIMS times; the top level holds the FSM and output registers.

Verification
REQ-038 Base 0x100, extents {4,3,1}, strides {4,0x40,0}, ready held 1 -> 12 consecutive addresses 0x100,0x104,0x108,0x10C,0x140..0x18C; addr_last only on 0x18C; done one cycle later.
REQ-039 Same configuration with ready toggling 1,0,0,1... -> identical address sequence; addr stable on every cycle with valid=1 and ready=0.
REQ-040 Base 0xFFFFFFF8, extent0=4, stride0=4 -> 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4 (wrap).
REQ-041 Negative stride: base 0x40, extent0=3, stride0=0xFFFFFFF0 -> 0x40, 0x30, 0x20.
REQ-042 cfg_repeat=1 with extents {2,1,1}, stride0=8, base 0 -> 0,8,0,8... with no gap; abort mid-sequence -> valid drops next cycle with one done pulse.
REQ-043 rst asserted mid-scan -> outputs cleared immediately with no done pulse; a subsequent start replays the sequence from cfg_base.
